// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer and the instruction decoder.
package cpu_sequencer_pkg;

  // Sequencer states; values are visible on the debug state port.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  // Next-PC source select.
  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  // Register write-source codes shared with the decoder.
  localparam logic [1:0] WSRC_MEM = 2'b00;
  localparam logic [1:0] WSRC_IMM = 2'b01;
  localparam logic [1:0] WSRC_RES = 2'b10;
  localparam logic [1:0] WSRC_ALU = 2'b11;

  // Instruction class flags captured in DECODE and used through WB.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic cpout;
  } dec_flags_t;

  // Jump beats branch if the decoder ever raises both.
  function automatic logic [1:0] pc_select(input logic jump, input logic taken);
    if (jump) begin
      return PCSEL_JMP;
    end else if (taken) begin
      return PCSEL_BR;
    end
    return PCSEL_INC;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Data-memory wait counter: counts stalled MEM cycles and flags the final allowed one.
module seq_timeout_counter #(
  parameter int unsigned Limit = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic last
);

  // Only values 0..Limit-1 are ever held.
  localparam int unsigned W = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [W-1:0] LastVal = W'(Limit - 1);

  logic [W-1:0] count_q, count_d;

  // Clear has priority; the count never steps past the final value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr && (count_q != LastVal)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A stall in this cycle would take the count to Limit.
  assign last = (count_q == LastVal);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with halt and memory timeout.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 dec_mem_read,
  input  logic                 dec_mem_write,
  input  logic                 dec_branch,
  input  logic                 dec_jump,
  input  logic                 dec_halt,
  input  logic                 dec_cpin,
  input  logic                 dec_cpout,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_we,
  output logic                 res_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 halted,
  output logic                 mem_err,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_e               state_q, state_d;
  dec_flags_t           flags_q, flags_d;
  logic                 taken_q, taken_d;
  logic                 mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timeout_last;

  // cpin writes the register file through the ordinary reg_we path, so it needs no flag.
  logic unused_cpin;
  assign unused_cpin = dec_cpin;

  seq_timeout_counter #(
    .Limit(MEM_TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clear(state_q != StMem),
    .incr ((state_q == StMem) && !dmem_ready),
    .last (timeout_last)
  );

  // State and per-instruction bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      flags_q   <= '0;
      taken_q   <= 1'b0;
      mem_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      taken_q   <= taken_d;
      mem_err_q <= mem_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic and flag capture.
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    taken_d   = taken_q;
    mem_err_d = mem_err_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready) state_d = StDecode;
      end
      StDecode: begin
        if (dec_halt) begin
          state_d = StHalt;
        end else begin
          flags_d = '{mem_read:  dec_mem_read,
                      mem_write: dec_mem_write,
                      branch:    dec_branch,
                      jump:      dec_jump,
                      cpout:     dec_cpout};
          state_d = StExec;
        end
      end
      StExec: begin
        taken_d = flags_q.branch & branch_taken;
        state_d = (flags_q.mem_read || flags_q.mem_write) ? StMem : StWb;
      end
      StMem: begin
        // A completion on the final allowed cycle still counts as success.
        if (dmem_ready) begin
          state_d = StWb;
        end else if (timeout_last) begin
          state_d   = StHalt;
          mem_err_d = 1'b1;
        end
      end
      StWb: begin
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the registered state; WB uses flags captured earlier.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    res_we   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PCSEL_INC;
    halted   = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = flags_q.mem_write;
      end
      StWb: begin
        pc_we  = 1'b1;
        pc_sel = pc_select(flags_q.jump, taken_q);
        res_we = flags_q.cpout;
        reg_we = !(flags_q.mem_write || flags_q.branch || flags_q.jump || flags_q.cpout);
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem_err     = mem_err_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed table, random instructions, halt/timeout/reset cases.
module tb_cpu_sequencer;

  localparam int unsigned CW = 4;
  localparam int         TO = 15;

  logic          clk = 1'b0;
  logic          reset, start, imem_ready, dmem_ready;
  logic          dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt, dec_cpin, dec_cpout;
  logic          branch_taken;
  logic          imem_req, ir_load, dmem_req, dmem_we, reg_we, res_we, pc_we, halted, mem_err;
  logic [1:0]    pc_sel;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  cpu_sequencer #(
    .CNT_WIDTH  (CW),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .dec_mem_read (dec_mem_read),
    .dec_mem_write(dec_mem_write),
    .dec_branch   (dec_branch),
    .dec_jump     (dec_jump),
    .dec_halt     (dec_halt),
    .dec_cpin     (dec_cpin),
    .dec_cpout    (dec_cpout),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_we       (reg_we),
    .res_we       (res_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .halted       (halted),
    .mem_err      (mem_err),
    .state        (state),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  // One instruction: decode class, environment waits, and expected observations.
  typedef struct {
    bit rd, wr, br, jmp, hlt, cpin, cpout, taken;
    int iw;     // FETCH cycles with imem_ready low
    int dw;     // MEM cycles with dmem_ready low
    int abort;  // assert reset after this many MEM cycles (0 = never)
    int cyc;    // cycles from first FETCH to WB, or until HALT is seen
    int mc;     // MEM cycles
    int wc;     // MEM cycles with dmem_we
    int ps;
    bit rw, sw, hl, er;
  } vec_t;

  int            n_pass = 0;
  int            n_total = 0;
  logic [CW-1:0] model_cnt;
  vec_t          tbl[12];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  function automatic vec_t mk(bit rd, bit wr, bit br, bit jmp, bit hlt, bit cpin, bit cpout,
                              bit taken, int iw, int dw, int cyc, int mc, int wc, int ps,
                              bit rw, bit sw, bit hl, bit er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.br = br; v.jmp = jmp; v.hlt = hlt; v.cpin = cpin;
    v.cpout = cpout; v.taken = taken; v.iw = iw; v.dw = dw; v.abort = 0;
    v.cyc = cyc; v.mc = mc; v.wc = wc; v.ps = ps; v.rw = rw; v.sw = sw; v.hl = hl; v.er = er;
    return v;
  endfunction

  // Reference: expectations from the instruction-level rules (latency, priorities, timeout).
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    bit mem = v.rd || v.wr;
    bit tmo = mem && (v.dw >= TO);
    r.mc = mem ? (tmo ? TO : v.dw + 1) : 0;
    r.wc = v.wr ? r.mc : 0;
    if (v.hlt) begin
      r.cyc = v.iw + 2; r.mc = 0; r.wc = 0; r.hl = 1; r.er = 0;
    end else begin
      r.cyc = (v.iw + 1) + 2 + r.mc + (tmo ? 0 : 1);
      r.hl = tmo; r.er = tmo;
    end
    r.ps = v.jmp ? 2 : ((v.br && v.taken) ? 1 : 0);
    r.rw = !(v.wr || v.br || v.jmp || v.cpout);
    r.sw = v.cpout;
    return r;
  endfunction

  task automatic run(input vec_t v, input string nm);
    int cyc = 0, f = 0, m = 0, w = 0, irl = 0;
    bit done = 0, wb = 0, aborted = 0;
    logic [1:0] ps = 2'b00;
    logic rw = 1'b0, sw = 1'b0;
    dec_mem_read = v.rd; dec_mem_write = v.wr; dec_branch = v.br; dec_jump = v.jmp;
    dec_halt = v.hlt; dec_cpin = v.cpin; dec_cpout = v.cpout; branch_taken = v.taken;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (halted) begin
        done = 1;
      end else begin
        if (i == 0) check({nm, " instr_count"}, 32'(instr_count), 32'(model_cnt));
        imem_ready = imem_req && (f >= v.iw);
        dmem_ready = dmem_req && (m >= v.dw);
        #1;
        cyc++;
        if (imem_req) f++;
        if (ir_load) irl++;
        if (dmem_req) begin
          m++;
          if (dmem_we) w++;
        end
        if (v.abort != 0 && m == v.abort) begin
          reset = 1'b1;
          #1;
          check({nm, " dmem_req after reset"}, 32'(dmem_req), 0);
          check({nm, " state after reset"}, 32'(state), 0);
          aborted = 1;
          done = 1;
        end else if (pc_we) begin
          ps = pc_sel; rw = reg_we; sw = res_we;
          wb = 1;
          done = 1;
        end
      end
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    if (!done) begin
      check({nm, " completion within budget"}, 0, 1);
    end else if (!aborted) begin
      check({nm, " cycles"}, 32'(cyc), 32'(v.cyc));
      check({nm, " fetch cycles"}, 32'(f), 32'(v.iw + 1));
      check({nm, " ir_load pulses"}, 32'(irl), 1);
      check({nm, " dmem_req cycles"}, 32'(m), 32'(v.mc));
      check({nm, " dmem_we cycles"}, 32'(w), 32'(v.wc));
      check({nm, " halted"}, 32'(halted), 32'(v.hl));
      check({nm, " mem_err"}, 32'(mem_err), 32'(v.er));
      if (wb) begin
        check({nm, " pc_sel"}, 32'(ps), 32'(v.ps));
        check({nm, " reg_we"}, 32'(rw), 32'(v.rw));
        check({nm, " res_we"}, 32'(sw), 32'(v.sw));
      end
      if (!v.hl) model_cnt = model_cnt + 1'b1;
    end
  endtask

  task automatic do_reset(input string nm);
    #2;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check({nm, " outputs zero in reset"},
          32'({imem_req, ir_load, dmem_req, dmem_we, reg_we, res_we, pc_we, pc_sel, halted,
               mem_err}), 0);
    check({nm, " state in reset"}, 32'(state), 0);
    check({nm, " instr_count in reset"}, 32'(instr_count), 0);
    @(negedge clk);
    reset = 1'b0;
    model_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    check({nm, " idle without start"}, 32'(state), 0);
  endtask

  task automatic check_halt_frozen(input string nm, input logic err);
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({nm, " state stays HALT"}, 32'(state), 6);
    check({nm, " halted held"}, 32'(halted), 1);
    check({nm, " mem_err held"}, 32'(mem_err), 32'(err));
    check({nm, " count frozen"}, 32'(instr_count), 32'(model_cnt));
    start = 1'b0;
  endtask

  initial begin
    vec_t v;
    reset = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    dec_mem_read = 0; dec_mem_write = 0; dec_branch = 0; dec_jump = 0;
    dec_halt = 0; dec_cpin = 0; dec_cpout = 0; branch_taken = 0;
    model_cnt = '0;

    //            rd wr br jp ht ci co tk iw dw cyc mc wc ps rw sw hl er
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4,  0, 0, 0, 1, 0, 0, 0);  // add
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 6,  0, 0, 0, 1, 0, 0, 0);  // add, slow fetch
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 8,  4, 0, 0, 1, 0, 0, 0);  // load, 3 waits
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4,  0, 0, 1, 0, 0, 0, 0);  // branch taken
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 0);  // branch not taken
    tbl[5]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 4,  0, 0, 2, 0, 0, 0, 0);  // jump + branch
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4,  0, 0, 0, 0, 1, 0, 0);  // cpout
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5,  1, 1, 0, 0, 0, 0, 0);  // store
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4,  0, 0, 0, 1, 0, 0, 0);  // cpin
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 14, 19, 15, 0, 0, 1, 0, 0, 0); // ready on last cycle
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4,  0, 0, 0, 1, 0, 0, 0);  // taken, no branch
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 8,  3, 3, 0, 0, 0, 0, 0);  // store, waits

    do_reset("por");
    start = 1'b1;
    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Random instruction stream; the 4-bit counter wraps along the way.
    for (int i = 0; i < 40; i++) begin
      v = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 6),
             0, 0, 0, 0, 0, 0, 0, 0);
      run(model(v), $sformatf("rnd%0d", i));
    end

    // Halt instruction after five retirements.
    do_reset("halt");
    start = 1'b1;
    for (int i = 0; i < 5; i++) run(tbl[0], $sformatf("pre_halt%0d", i));
    run(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0), "halt_instr");
    check("halt count is five", 32'(instr_count), 5);
    check_halt_frozen("halt", 1'b0);

    // Store that never completes times out into an error halt.
    do_reset("tmo");
    start = 1'b1;
    run(tbl[0], "pre_tmo");
    run(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1000, 18, 15, 15, 0, 0, 0, 1, 1), "store_timeout");
    check_halt_frozen("tmo", 1'b1);
    do_reset("post_tmo");

    // Reset in the middle of a load wait.
    start = 1'b1;
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1000, 0, 0, 0, 0, 0, 0, 0, 0);
    v.abort = 2;
    run(v, "abort_mem");
    @(negedge clk);
    reset = 1'b0;
    model_cnt = '0;
    @(negedge clk);
    check("abort idle", 32'(state), 0);
    check("abort no request", 32'({imem_req, dmem_req, dmem_we, halted, mem_err}), 0);
    start = 1'b1;
    run(tbl[0], "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
